// File: rtl/dma16.sv
// dma16: memory-to-memory copy engine. The CPU programs SRC/DST/LEN through
// four registers, then a start request parks the CPU via hold and the engine
// copies LEN words over the system bus, one read and one write per word.
`timescale 1ns/1ps
module dma16 #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_sel,
  input  logic [1:0]            reg_addr,
  input  logic                  reg_we,
  input  logic [DATA_WIDTH-1:0] reg_din,
  output logic [DATA_WIDTH-1:0] reg_dout,
  output logic                  hold,
  input  logic                  cpu_busy,
  output logic                  bus_en,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_dout,
  input  logic [DATA_WIDTH-1:0] bus_din,
  output logic                  bus_we
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_RD_DATA,
    S_WR,
    S_RELEASE
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] src, dst;
  logic [DATA_WIDTH-1:0] len, data;
  logic                  done, abort_q;
  logic                  reg_wr, start_wr, abort_wr, active;

  assign reg_wr   = reg_sel & reg_we;
  assign start_wr = reg_wr && (reg_addr == 2'd3) && reg_din[0];
  assign abort_wr = reg_wr && (reg_addr == 2'd3) && reg_din[1];
  assign active   = (state != S_IDLE);

  // Register readback; SRC/DST/LEN are the live counters
  always_comb begin
    reg_dout = '0;
    case (reg_addr)
      2'd0:    reg_dout = DATA_WIDTH'(src);
      2'd1:    reg_dout = DATA_WIDTH'(dst);
      2'd2:    reg_dout = len;
      default: reg_dout = {{(DATA_WIDTH-2){1'b0}}, done, active};
    endcase
  end

  // Next-state and bus outputs, decoded from the current state
  always_comb begin
    state_next = state;
    hold       = 1'b0;
    bus_en     = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_dout   = '0;
    case (state)
      S_IDLE: begin
        if (start_wr && (len != '0)) state_next = S_REQ;
      end
      S_REQ: begin
        hold = 1'b1;
        if (abort_q)       state_next = S_RELEASE;
        else if (!cpu_busy) state_next = S_RD;
      end
      S_RD: begin
        hold = 1'b1;
        // A pending abort is honoured here, before any bus cycle of a new word
        if (abort_q) begin
          state_next = S_RELEASE;
        end else begin
          bus_en     = 1'b1;
          bus_addr   = src;
          state_next = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        hold       = 1'b1;
        bus_en     = 1'b1;
        bus_addr   = src;
        state_next = S_WR;
      end
      S_WR: begin
        hold       = 1'b1;
        bus_en     = 1'b1;
        bus_we     = 1'b1;
        bus_addr   = dst;
        bus_dout   = data;
        state_next = (len == DATA_WIDTH'(1)) ? S_RELEASE : S_RD;
      end
      S_RELEASE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register, programming registers, counters and the abort latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      src     <= '0;
      dst     <= '0;
      len     <= '0;
      data    <= '0;
      done    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (reg_wr) begin
            case (reg_addr)
              2'd0:    src <= ADDR_WIDTH'(reg_din);
              2'd1:    dst <= ADDR_WIDTH'(reg_din);
              2'd2:    len <= reg_din;
              default: ;
            endcase
          end
          // A zero-length start completes at once without requesting the bus
          if (start_wr) done <= (len == '0);
        end
        S_RD_DATA: data <= bus_din;
        S_WR: begin
          src <= src + ADDR_WIDTH'(1);
          dst <= dst + ADDR_WIDTH'(1);
          len <= len - DATA_WIDTH'(1);
        end
        S_RELEASE: done <= 1'b1;
        default: ;
      endcase
      if (state_next == S_IDLE)
        abort_q <= 1'b0;
      else if (abort_wr && (state != S_IDLE))
        abort_q <= 1'b1;
    end
  end

endmodule

// File: doc/dma16.md
Name: dma16

Overview:
- Memory-to-memory copy engine for the 16-bit system; a second bus initiator alongside the CPU.
- The CPU programs source, destination and length through four memory-mapped registers.
- On start, the engine asks the CPU to park with hold, waits for the CPU to report parked (busy low), then drives the system bus itself.
- It copies LEN words from synchronous memory, one read and one write per word, then releases hold.

Parameters:
- ADDR_WIDTH, 16, width of bus address and of SRC/DST registers.
- DATA_WIDTH, 16, width of bus data and of the register interface.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- reg_sel  input  1  register-block select, decoded by the system.
- reg_addr  input  2  register index: 0 SRC, 1 DST, 2 LEN, 3 CTRL/STATUS.
- reg_we  input  1  register write strobe, qualified by reg_sel.
- reg_din  input  DATA_WIDTH  register write data.
- reg_dout  output  DATA_WIDTH  combinational readback of the register at reg_addr.
- hold  output  1  request to the CPU to park.
- cpu_busy  input  1  CPU status; low while hold is high means the CPU is parked and off the bus.
- bus_en  output  1  engine owns the bus; the system muxes addr/dout/we from the engine while high.
- bus_addr  output  ADDR_WIDTH  bus address.
- bus_dout  output  DATA_WIDTH  bus write data.
- bus_din  input  DATA_WIDTH  bus read data; synchronous memory, valid the cycle after the address.
- bus_we  output  1  bus write enable.

Behaviour:
- Reset values: all registers 0, state IDLE, done 0. Outputs hold, bus_en, bus_we = 0; bus_addr, bus_dout = 0. Reset mid-transfer drops hold, bus_en and bus_we on the next edge; no further bus writes occur.
- Register writes (reg_sel & reg_we):
  - In IDLE: addr 0/1/2 load SRC/DST/LEN.
  - addr 3, bit0=1 is start; bit1=1 is abort.
  - In any state other than IDLE, writes to 0–2 and start are ignored; abort is accepted.
- Readback: addr 0/1/2 return the live SRC/DST/LEN, which count during a transfer. addr 3 returns {14'b0, done, active}; active = (state != IDLE).
- Start in IDLE: clears done.
  - LEN==0: done set next cycle; hold is never asserted; stays IDLE.
  - Otherwise go to REQ.
- REQ: hold=1, bus_en=0. Wait while cpu_busy=1. cpu_busy=0 goes to RD. No timeout.
- RD: checks the abort latch first; if set, go to RELEASE. Otherwise bus_en=1, bus_addr=SRC, bus_we=0, go to RD_DATA.
- RD_DATA: bus_en=1, bus_we=0, bus_addr=SRC. Latch bus_din into the data register; go to WR.
- WR:
  - bus_en=1, bus_we=1 for exactly this cycle, bus_addr=DST, bus_dout=latched data.
  - At the edge: SRC+=1, DST+=1 (mod 2^ADDR_WIDTH, silent wrap 0xFFFF→0x0000), LEN-=1.
  - If the new LEN==0 go to RELEASE, else go to RD.
- Throughput: 3 cycles per word once granted.
- RELEASE: hold=0, bus_en=0, done=1; next state IDLE.
- Abort:
  - Latched from a write in any non-IDLE state; cleared on entry to IDLE.
  - In REQ, it moves to RELEASE immediately; no bus cycle is issued.
  - In RD_DATA or WR, the current word completes; it takes effect at the next RD.
  - done is set on abort; LEN shows the remaining count.
- Simultaneous events:
  - A start write in the same cycle as RELEASE→IDLE is ignored.
  - A register write and WR on the same edge: the counters update and the write is dropped.
- hold remains 1 through REQ, RD, RD_DATA and WR. bus_en is never 1 while hold is 0.

Test Plan:
- Preload RAM[0x0010..0x0013]=0xA001..0xA004; SRC=0x0010, DST=0x0100, LEN=4, start, cpu_busy falls 2 cycles after hold. Required:
  - RAM[0x0100..0x0103]=0xA001..0xA004.
  - Exactly 4 bus_we pulses, 3 cycles apart.
  - After completion: hold low, STATUS=0x0002, SRC=0x0014, DST=0x0104, LEN=0.
- LEN=0, start → hold never rises; STATUS=0x0002 on the next cycle.
- cpu_busy held high for 50 cycles after start → bus_en stays 0 and no writes occur; copy proceeds after cpu_busy falls.
- SRC=0xFFFE, DST=0x0200, LEN=3 → reads 0xFFFE, 0xFFFF, 0x0000 in order; final SRC=0x0001.
- LEN=8, abort written during the RD_DATA of word 2:
  - word 2 is written;
  - writes total 3 (words 0–2);
  - LEN reads 5; done=1.
- reset asserted mid-WR of word 1 of 4:
  - next cycle hold=0, bus_en=0, bus_we=0;
  - all registers read 0;
  - no further writes.
